vai_mmio_initiator: RTL and testbench
=====================================

// Module: vai_mmio_initiator
// PURPOSE
// Requester side of the CCI-P MMIO channel: issues MMIO reads/writes (c0 mmioRd/mmioWr style) towards
// a downstream responder (manager or sub-AFU) and collects c2 read responses by tid. Sits in the nested
// VAI mux wherever a parent must configure a child (offsets, sub-AFU reset, DFH/ID probe). Tracks up to
// MAX_OUTSTANDING reads, restores the user tag, and synthesises an all-ones timeout response.
// PARAMETERS
// MAX_OUTSTANDING  4     read slots; power of 2, 2..16; tid = slot index zero-extended to 9 bits
// TAG_W            8     width of user tag carried from cmd to rsp
// TIMEOUT          1024  cycles a read waits for its response before synthetic completion; >=4
// PORTS
// clk              in   1     clock
// reset            in   1     synchronous, active-high reset
// cmd_valid        in   1     command offered
// cmd_ready        out  1     command accepted when valid&ready
// cmd_write        in   1     1=MMIO write, 0=MMIO read
// cmd_addr         in   16    MMIO address, DW units; bit0 forced to 0 on issue (64-bit access only)
// cmd_data         in   64    write data (ignored for reads)
// cmd_tag          in   TAG_W tag returned with read response (ignored for writes)
// mmio_rd_valid    out  1     read request pulse to responder
// mmio_wr_valid    out  1     write request pulse to responder
// mmio_addr        out  16    request address
// mmio_tid         out  9     request tid
// mmio_data        out  64    write data; 0 on reads
// c2_rsp_valid     in   1     read response from responder
// c2_rsp_tid       in   9     tid of response
// c2_rsp_data      in   64    response data
// rsp_valid        out  1     completed read to user, single-cycle pulse, no backpressure
// rsp_tag          out  TAG_W tag of completed read
// rsp_data         out  64    read data, 64'hFFFF_FFFF_FFFF_FFFF on timeout
// rsp_timeout      out  1     completion was synthesised by timeout
// busy             out  1     any read slot occupied
// err_stray        out  1     sticky: response arrived for a free slot or tid >= MAX_OUTSTANDING
// BEHAVIOUR
// - Reset: all outputs 0 (mmio_*, rsp_*, err_stray, busy), all slots free; cmd_ready is 0 during reset.
// - Issue latency 1: cmd accepted cycle N -> mmio_*_valid/addr/tid/data registered, asserted cycle N+1
//   for exactly one cycle. At most one request issued per cycle; no backpressure from responder.
// - cmd_ready = !reset && (cmd_write || any slot free). Writes never occupy a slot; write tid = 0.
// - Read: allocate lowest-index free slot s; store tag, start timer=0; issue with tid=s.
// - Slot lifecycle: FREE -> PENDING (on issue) -> FREE (on matching response or timeout completion).
// - Response latency 1: c2_rsp_valid with tid=s of PENDING slot at cycle N -> rsp_valid/rsp_tag(slot)/
//   rsp_data=c2_rsp_data, rsp_timeout=0 at N+1; slot free at N+1 (reusable by cmd accepted at N+1).
// - Timer: each PENDING slot increments per cycle, saturates at TIMEOUT. Slot at TIMEOUT is EXPIRED.
// - Timeout completion: when no valid matching c2 response this cycle, lowest-index EXPIRED slot
//   completes next cycle with data all-ones, rsp_timeout=1; other expired slots wait, one per cycle.
// - Priority: real response beats timeout completion in same cycle; an expired slot whose real
//   response arrives before its timeout completion is emitted completes with real data, rsp_timeout=0.
// - Stray: response whose tid is >= MAX_OUTSTANDING or names a FREE slot is dropped, err_stray<=1
//   (sticky until reset); no rsp_valid. Late responses after timeout completion are therefore stray.
// - Simultaneous read issue and completion of a different slot: both proceed same cycle.
// - Reset mid-operation: pending reads discarded without rsp; requests in flight are not recalled.
// - busy = OR of PENDING/EXPIRED slot flags, registered with slot state.
// TESTING
// - Write cmd addr 0x000D data 0x55 -> cycle+1: mmio_wr_valid=1, addr 0x000C, tid 0, data 0x55, 1 cycle.
// - Read tag 0x3A, responder answers tid 0 data 0x1234 5 cycles later -> rsp_valid, tag 0x3A, data 0x1234.
// - 4 reads tags 1..4, responses tid 3,1,0,2 -> rsp tags 4,2,1,3 in that order; 5th read waits on cmd_ready.
// - No response, TIMEOUT=16 -> rsp_timeout=1, data all-ones 18 cycles after issue; later tid-0 rsp -> err_stray=1.
// - Two reads expire same cycle while tid 1 response arrives -> tid1 real data first, then slot 0, then 2.
// - Reset with 3 pending reads -> no rsp_valid, busy=0, cmd_ready=1 after reset deasserts.

Source files
------------

// File: rtl/vai_mmio_initiator_if.sv
// Bundle of the MMIO initiator's command, request, response and status signals.
// master = the initiator itself; slave = the user / responder environment around it.
interface vai_mmio_initiator_if #(
   parameter int unsigned TAG_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [15:0]      cmd_addr;
   logic [63:0]      cmd_data;
   logic [TAG_W-1:0] cmd_tag;

   logic             mmio_rd_valid;
   logic             mmio_wr_valid;
   logic [15:0]      mmio_addr;
   logic [8:0]       mmio_tid;
   logic [63:0]      mmio_data;

   logic             c2_rsp_valid;
   logic [8:0]       c2_rsp_tid;
   logic [63:0]      c2_rsp_data;

   logic             rsp_valid;
   logic [TAG_W-1:0] rsp_tag;
   logic [63:0]      rsp_data;
   logic             rsp_timeout;

   logic             busy;
   logic             err_stray;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_tag,
      input  c2_rsp_valid, c2_rsp_tid, c2_rsp_data,
      output cmd_ready,
      output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_data,
      output rsp_valid, rsp_tag, rsp_data, rsp_timeout,
      output busy, err_stray
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_tag,
      output c2_rsp_valid, c2_rsp_tid, c2_rsp_data,
      input  cmd_ready,
      input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_data,
      input  rsp_valid, rsp_tag, rsp_data, rsp_timeout,
      input  busy, err_stray
   );
endinterface

// File: rtl/vai_mmio_initiator.sv
// CCI-P MMIO requester: issues reads/writes to a responder, tracks reads in tid-indexed slots,
// restores the user tag on completion and synthesises an all-ones response on timeout.
module vai_mmio_initiator #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TAG_W           = 8,
   parameter int unsigned TIMEOUT         = 1024
) (
   input logic                  clk,
   input logic                  reset,
   vai_mmio_initiator_if.master bus
);
   localparam int unsigned IDX_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic {
      SLOT_FREE    = 1'b0,
      SLOT_PENDING = 1'b1
   } slot_state_t;

   slot_state_t      slot_state [MAX_OUTSTANDING];
   logic [TMR_W-1:0] slot_timer [MAX_OUTSTANDING];
   logic [TAG_W-1:0] slot_tag   [MAX_OUTSTANDING];

   logic                       any_free;
   logic [IDX_W-1:0]           alloc_idx;
   logic                       any_expired;
   logic [IDX_W-1:0]           to_idx;
   logic                       cmd_ready;
   logic                       cmd_accept;
   logic                       rd_alloc;
   logic [IDX_W-1:0]           rsp_idx;
   logic                       rsp_in_range;
   logic                       rsp_hit;
   logic                       rsp_stray;
   logic                       to_fire;
   logic                       done_valid;
   logic [IDX_W-1:0]           done_idx;
   logic [MAX_OUTSTANDING-1:0] pend_next;

   always_comb begin
      any_free    = 1'b0;
      alloc_idx   = '0;
      any_expired = 1'b0;
      to_idx      = '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         if (slot_state[i] == SLOT_FREE && !any_free) begin
            any_free  = 1'b1;
            alloc_idx = IDX_W'(i);
         end
         if (slot_state[i] == SLOT_PENDING && slot_timer[i] == TMR_W'(TIMEOUT) && !any_expired) begin
            any_expired = 1'b1;
            to_idx      = IDX_W'(i);
         end
      end

      cmd_ready  = !reset && (bus.cmd_write || any_free);
      cmd_accept = bus.cmd_valid && cmd_ready;
      rd_alloc   = cmd_accept && !bus.cmd_write;

      rsp_idx      = bus.c2_rsp_tid[IDX_W-1:0];
      rsp_in_range = bus.c2_rsp_tid < 9'(MAX_OUTSTANDING);
      rsp_hit      = bus.c2_rsp_valid && rsp_in_range && slot_state[rsp_idx] == SLOT_PENDING;
      rsp_stray    = bus.c2_rsp_valid && !rsp_hit;

      // A real response always wins; an expired slot simply waits another cycle.
      to_fire    = !rsp_hit && any_expired;
      done_valid = rsp_hit || to_fire;
      done_idx   = rsp_hit ? rsp_idx : to_idx;

      pend_next = '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         pend_next[i] = (slot_state[i] == SLOT_PENDING && !(done_valid && done_idx == IDX_W'(i)))
                      || (rd_alloc && alloc_idx == IDX_W'(i));
      end
   end

   assign bus.cmd_ready = cmd_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mmio_rd_valid <= 1'b0;
         bus.mmio_wr_valid <= 1'b0;
         bus.mmio_addr     <= '0;
         bus.mmio_tid      <= '0;
         bus.mmio_data     <= '0;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_tag       <= '0;
         bus.rsp_data      <= '0;
         bus.rsp_timeout   <= 1'b0;
         bus.busy          <= 1'b0;
         bus.err_stray     <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            slot_state[i] <= SLOT_FREE;
            slot_timer[i] <= '0;
            slot_tag[i]   <= '0;
         end
      end else begin
         bus.mmio_rd_valid <= rd_alloc;
         bus.mmio_wr_valid <= cmd_accept && bus.cmd_write;
         if (cmd_accept) begin
            bus.mmio_addr <= bus.cmd_addr & 16'hFFFE;
            bus.mmio_tid  <= bus.cmd_write ? 9'd0 : 9'(alloc_idx);
            bus.mmio_data <= bus.cmd_write ? bus.cmd_data : 64'd0;
         end

         bus.rsp_valid   <= done_valid;
         bus.rsp_timeout <= to_fire;
         if (done_valid) begin
            bus.rsp_tag  <= slot_tag[done_idx];
            bus.rsp_data <= rsp_hit ? bus.c2_rsp_data : '1;
         end

         if (rsp_stray)
            bus.err_stray <= 1'b1;
         bus.busy <= |pend_next;

         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            slot_state[i] <= pend_next[i] ? SLOT_PENDING : SLOT_FREE;
            if (rd_alloc && alloc_idx == IDX_W'(i)) begin
               slot_timer[i] <= '0;
               slot_tag[i]   <= bus.cmd_tag;
            end else if (!pend_next[i]) begin
               slot_timer[i] <= '0;
            end else if (slot_timer[i] != TMR_W'(TIMEOUT)) begin
               slot_timer[i] <= slot_timer[i] + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_vai_mmio_initiator.sv
// Directed bench for vai_mmio_initiator: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_vai_mmio_initiator;
   logic clk = 1'b0;
   logic reset;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vai_mmio_initiator_if #(.TAG_W(8)) bus ();

   vai_mmio_initiator #(
      .MAX_OUTSTANDING(4),
      .TAG_W(8),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic        cv;     logic        cw;     logic [15:0] ca;     logic [63:0] cd;
      logic [7:0]  ct;     logic        c2v;    logic [8:0]  c2t;    logic [63:0] c2d;
      logic        e_rdy;  logic        e_rd;   logic        e_wr;   logic [15:0] e_addr;
      logic [8:0]  e_tid;  logic [63:0] e_md;   logic        e_rspv; logic [7:0]  e_tag;
      logic [63:0] e_rd_d; logic        e_to;   logic        e_busy; logic        e_err;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cv, input logic cw, input logic [15:0] ca, input logic [63:0] cd,
                        input logic [7:0] ct, input logic c2v, input logic [8:0] c2t, input logic [63:0] c2d);
      bus.cmd_valid    = cv;
      bus.cmd_write    = cw;
      bus.cmd_addr     = ca;
      bus.cmd_data     = cd;
      bus.cmd_tag      = ct;
      bus.c2_rsp_valid = c2v;
      bus.c2_rsp_tid   = c2t;
      bus.c2_rsp_data  = c2d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b0, 9'd0, 64'h0);
   endtask

   task automatic rd(input logic [7:0] tag);
      drive(1'b1, 1'b0, 16'h0040, 64'h0, tag, 1'b0, 9'd0, 64'h0);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Expects a completion visible in the current cycle.
   task automatic chk_rsp(input string name, input logic [7:0] tag, input logic [63:0] data, input logic to);
      chk({name, "_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({name, "_tag"}, 64'(bus.rsp_tag), 64'(tag));
      chk({name, "_data"}, bus.rsp_data, data);
      chk({name, "_timeout"}, 64'(bus.rsp_timeout), 64'(to));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  found_k;
      logic seen;
      logic [7:0]  cap_tag;
      logic [63:0] cap_data;
      logic        cap_to;

      reset = 1'b1;
      idle();
      bus.cmd_write = 1'b1;
      step();
      step();
      chk("reset_ready", 64'(bus.cmd_ready), 64'd0);
      chk("reset_mmio_rd", 64'(bus.mmio_rd_valid), 64'd0);
      chk("reset_mmio_wr", 64'(bus.mmio_wr_valid), 64'd0);
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_err", 64'(bus.err_stray), 64'd0);
      reset = 1'b0;
      idle();

      // ---------- table-driven single-cycle vectors ----------
      vecs[0]  = '{1'b1, 1'b1, 16'h000D, 64'h55, 8'h00, 1'b0, 9'd0, 64'h0,
                   1'b1, 1'b0, 1'b1, 16'h000C, 9'd0, 64'h55, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 16'h0, 64'h0, 8'h00, 1'b0, 9'd0, 64'h0,
                   1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 16'h0011, 64'hFFFF, 8'h3A, 1'b0, 9'd0, 64'h0,
                   1'b1, 1'b1, 1'b0, 16'h0010, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0};
      for (int i = 3; i <= 7; i++)
         vecs[i] = '{1'b0, 1'b0, 16'h0, 64'h0, 8'h00, 1'b0, 9'd0, 64'h0,
                     1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0, 64'h0, 8'h00, 1'b1, 9'd0, 64'h1234,
                   1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 64'h0, 1'b1, 8'h3A, 64'h1234, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 16'h0, 64'h0, 8'h00, 1'b0, 9'd0, 64'h0,
                   1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 16'h0, 64'h0, 8'h00, 1'b1, 9'd5, 64'hDEAD,
                   1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 16'h0020, 64'h0, 8'h11, 1'b1, 9'd0, 64'h99,
                   1'b1, 1'b1, 1'b0, 16'h0020, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 16'h0003, 64'hCAFE, 8'hEE, 1'b1, 9'd0, 64'h77,
                   1'b1, 1'b0, 1'b1, 16'h0002, 9'd0, 64'hCAFE, 1'b1, 8'h11, 64'h77, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 16'h0, 64'h0, 8'h00, 1'b0, 9'd0, 64'h0,
                   1'b1, 1'b0, 1'b0, 16'h0, 9'd0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].cv, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].ct,
               vecs[i].c2v, vecs[i].c2t, vecs[i].c2d);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(bus.cmd_ready), 64'(vecs[i].e_rdy));
         step();
         chk($sformatf("v%0d_mmio_rd", i), 64'(bus.mmio_rd_valid), 64'(vecs[i].e_rd));
         chk($sformatf("v%0d_mmio_wr", i), 64'(bus.mmio_wr_valid), 64'(vecs[i].e_wr));
         if (vecs[i].e_rd || vecs[i].e_wr) begin
            chk($sformatf("v%0d_mmio_addr", i), 64'(bus.mmio_addr), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d_mmio_tid", i), 64'(bus.mmio_tid), 64'(vecs[i].e_tid));
            chk($sformatf("v%0d_mmio_data", i), bus.mmio_data, vecs[i].e_md);
         end
         chk($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].e_rspv));
         if (vecs[i].e_rspv) begin
            chk($sformatf("v%0d_rsp_tag", i), 64'(bus.rsp_tag), 64'(vecs[i].e_tag));
            chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].e_rd_d);
            chk($sformatf("v%0d_rsp_to", i), 64'(bus.rsp_timeout), 64'(vecs[i].e_to));
         end
         chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'(vecs[i].e_busy));
         chk($sformatf("v%0d_err", i), 64'(bus.err_stray), 64'(vecs[i].e_err));
      end

      // ---------- four reads, out-of-order responses, fifth read blocked ----------
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rd(8'(i + 1));
         step();
         chk($sformatf("ooo_issue%0d_rd", i), 64'(bus.mmio_rd_valid), 64'd1);
         chk($sformatf("ooo_issue%0d_tid", i), 64'(bus.mmio_tid), 64'(i));
      end
      drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'h05, 1'b1, 9'd3, 64'h33);
      #1;
      chk("ooo_full_ready", 64'(bus.cmd_ready), 64'd0);
      step();
      chk_rsp("ooo_rsp_t3", 8'h04, 64'h33, 1'b0);
      chk("ooo_no_issue_when_full", 64'(bus.mmio_rd_valid), 64'd0);
      drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'h05, 1'b1, 9'd1, 64'h11);
      #1;
      chk("ooo_ready_after_free", 64'(bus.cmd_ready), 64'd1);
      step();
      chk_rsp("ooo_rsp_t1", 8'h02, 64'h11, 1'b0);
      chk("ooo_fifth_rd", 64'(bus.mmio_rd_valid), 64'd1);
      chk("ooo_fifth_tid", 64'(bus.mmio_tid), 64'd3);
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b1, 9'd0, 64'h10);
      step();
      chk_rsp("ooo_rsp_t0", 8'h01, 64'h10, 1'b0);
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b1, 9'd2, 64'h22);
      step();
      chk_rsp("ooo_rsp_t2", 8'h03, 64'h22, 1'b0);
      chk("ooo_busy_fifth", 64'(bus.busy), 64'd1);
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b1, 9'd3, 64'h55);
      step();
      chk_rsp("ooo_rsp_fifth", 8'h05, 64'h55, 1'b0);
      chk("ooo_busy_end", 64'(bus.busy), 64'd0);
      idle();

      // ---------- single read times out: completion 18 cycles after the accept cycle ----------
      do_reset();
      rd(8'h9C);
      step();
      idle();
      found_k  = 0;
      cap_tag  = '0;
      cap_data = '0;
      cap_to   = 1'b0;
      for (int k = 1; k <= 30 && found_k == 0; k++) begin
         step();
         if (bus.rsp_valid) begin
            found_k  = k;
            cap_tag  = bus.rsp_tag;
            cap_data = bus.rsp_data;
            cap_to   = bus.rsp_timeout;
         end
      end
      chk("to_latency", 64'(found_k), 64'd17);
      chk("to_tag", 64'(cap_tag), 64'h9C);
      chk("to_data", cap_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("to_flag", 64'(cap_to), 64'd1);
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b1, 9'd0, 64'hABCD);
      step();
      idle();
      chk("late_rsp_no_valid", 64'(bus.rsp_valid), 64'd0);
      chk("late_rsp_err", 64'(bus.err_stray), 64'd1);
      chk("late_rsp_busy", 64'(bus.busy), 64'd0);

      // ---------- slots 0 and 2 expired together while tid 1 answers ----------
      do_reset();
      rd(8'hD0);                                             // c0 -> slot0
      step();
      rd(8'hD1);                                             // c1 -> slot1
      step();
      drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'hA2, 1'b1, 9'd0, 64'h0); // c2 -> slot2, free slot0
      step();
      chk_rsp("ex_free0", 8'hD0, 64'h0, 1'b0);
      drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'hA0, 1'b1, 9'd1, 64'h1); // c3 -> slot0, free slot1
      step();
      chk_rsp("ex_free1", 8'hD1, 64'h1, 1'b0);
      chk("ex_realloc0_tid", 64'(bus.mmio_tid), 64'd0);
      rd(8'hA1);                                             // c4 -> slot1
      step();
      chk("ex_realloc1_tid", 64'(bus.mmio_tid), 64'd1);
      rd(8'hA3);                                             // c5 -> slot3
      step();
      chk("ex_slot3_tid", 64'(bus.mmio_tid), 64'd3);
      idle();
      seen = 1'b0;
      for (int c = 6; c <= 18; c++) begin
         step();
         if (bus.rsp_valid) seen = 1'b1;
      end
      chk("ex_no_early_rsp", 64'(seen), 64'd0);
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b1, 9'd3, 64'h3333);  // c19: blocks slot2 timeout
      step();
      chk_rsp("ex_block_t3", 8'hA3, 64'h3333, 1'b0);
      drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b1, 9'd1, 64'hBEEF);  // c20: slots 0,2 expired
      step();
      idle();
      chk_rsp("ex_real_t1", 8'hA1, 64'hBEEF, 1'b0);
      step();
      chk_rsp("ex_to_slot0", 8'hA0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      step();
      chk_rsp("ex_to_slot2", 8'hA2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      step();
      chk("ex_done_valid", 64'(bus.rsp_valid), 64'd0);
      chk("ex_done_busy", 64'(bus.busy), 64'd0);
      chk("ex_no_stray", 64'(bus.err_stray), 64'd0);

      // ---------- reset with three reads pending ----------
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rd(8'(8'h60 + i));
         step();
      end
      chk("mid_busy_before", 64'(bus.busy), 64'd1);
      drive(1'b0, 1'b1, 16'h0, 64'h0, 8'h0, 1'b0, 9'd0, 64'h0);
      reset = 1'b1;
      #1;
      chk("mid_ready_in_reset", 64'(bus.cmd_ready), 64'd0);
      step();
      reset = 1'b0;
      idle();
      #1;
      chk("mid_busy_after", 64'(bus.busy), 64'd0);
      chk("mid_rsp_after", 64'(bus.rsp_valid), 64'd0);
      chk("mid_ready_after", 64'(bus.cmd_ready), 64'd1);
      seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (bus.rsp_valid) seen = 1'b1;
      end
      chk("mid_no_rsp", 64'(seen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
